// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
// Optional divide-by-zero trap is controlled by MULDIV_DIVZERO_TRAP_EN in muldiv_unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX
  } state_e;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_COUNT - 1);

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiply or restoring divide on operand magnitudes.
// The shift register holds |A|; bmag_i is |B| (multiplicand for mul, divisor for div).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             op_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] sreg_i,
  input  logic [WIDTH-1:0] bmag_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] sreg_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // The partial remainder is always below 2^WIDTH once shifted, so a
  // WIDTH+1 bit trial subtract has a trustworthy sign bit.
  always_comb begin
    sum  = {1'b0, acc_i} + (sreg_i[0] ? {1'b0, bmag_i} : '0);
    diff = {acc_i, sreg_i[WIDTH-1]} - {1'b0, bmag_i};
    if (op_i == OP_MUL) begin
      acc_o  = sum[WIDTH:1];
      sreg_o = {sum[0], sreg_i[WIDTH-1:1]};
    end else if (diff[WIDTH]) begin
      acc_o  = {acc_i[WIDTH-2:0], sreg_i[WIDTH-1]};
      sreg_o = {sreg_i[WIDTH-2:0], 1'b0};
    end else begin
      acc_o  = diff[WIDTH-1:0];
      sreg_o = {sreg_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle signed multiply/divide writing HI/LO; 33-cycle fixed latency.
// Define MULDIV_DIVZERO_TRAP_EN to enable the early-exit divide-by-zero trap.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             DivZero
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               op_q, signA_q, signB_q, done_q;
  logic [WIDTH-1:0]   acc_q, sreg_q, bmag_q, hi_q, lo_q;
  logic [WIDTH-1:0]   accStep, sregStep, absA, absB;
  logic [WIDTH-1:0]   quoFix, remFix, aRestored;
  logic [2*WIDTH-1:0] prodRaw, prodFix;

`ifdef MULDIV_DIVZERO_TRAP_EN
  logic divZero_q;
  logic trapHit;
  assign trapHit = (op_q == OP_DIV) && (bmag_q == '0);
  assign DivZero = divZero_q;
`else
  assign DivZero = 1'b0;
`endif

  muldiv_step #(.WIDTH(WIDTH)) uStep (
    .op_i   (op_q),
    .acc_i  (acc_q),
    .sreg_i (sreg_q),
    .bmag_i (bmag_q),
    .acc_o  (accStep),
    .sreg_o (sregStep)
  );

  // Magnitudes at issue time and sign correction of the finished result.
  always_comb begin
    absA      = A[WIDTH-1] ? -A : A;
    absB      = B[WIDTH-1] ? -B : B;
    prodRaw   = {acc_q, sreg_q};
    prodFix   = (signA_q ^ signB_q) ? -prodRaw : prodRaw;
    quoFix    = (signA_q ^ signB_q) ? -sreg_q : sreg_q;
    remFix    = signA_q ? -acc_q : acc_q;
    aRestored = signA_q ? -sreg_q : sreg_q;
  end

  always_ff @(posedge Clock) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (Start) state_d = ITER;
      ITER: begin
`ifdef MULDIV_DIVZERO_TRAP_EN
        if (trapHit) state_d = IDLE;
        else
`endif
        if (cnt_q == CNT_LAST) state_d = FIX;
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state_q != IDLE);
  end

  assign Done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

  // Datapath: operand latch, iteration registers and result registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q   <= '0;
      op_q    <= OP_MUL;
      signA_q <= 1'b0;
      signB_q <= 1'b0;
      acc_q   <= '0;
      sreg_q  <= '0;
      bmag_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
`ifdef MULDIV_DIVZERO_TRAP_EN
      divZero_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (Start) begin
          op_q    <= Op;
          signA_q <= A[WIDTH-1];
          signB_q <= B[WIDTH-1];
          sreg_q  <= absA;
          bmag_q  <= absB;
          acc_q   <= '0;
          cnt_q   <= '0;
`ifdef MULDIV_DIVZERO_TRAP_EN
          divZero_q <= 1'b0;
`endif
        end
        ITER: begin
`ifdef MULDIV_DIVZERO_TRAP_EN
          if (trapHit) begin
            hi_q      <= aRestored;
            lo_q      <= '0;
            divZero_q <= 1'b1;
            done_q    <= 1'b1;
          end else
`endif
          begin
            acc_q  <= accStep;
            sreg_q <= sregStep;
            cnt_q  <= cnt_q + CNT_W'(1);
          end
        end
        FIX: begin
          if (op_q == OP_MUL) begin
            hi_q <= prodFix[2*WIDTH-1:WIDTH];
            lo_q <= prodFix[WIDTH-1:0];
          end else begin
            hi_q <= remFix;
            lo_q <= quoFix;
          end
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO/DivZero and
// the Done cycle; a monitor pops and compares on every Done pulse.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset, Start, Op;
  logic [31:0] A, B;
  logic        Busy, Done, DivZero;
  logic [31:0] HI, LO;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

`ifdef MULDIV_DIVZERO_TRAP_EN
  localparam int          DZ_LAT = 1;
  localparam logic [31:0] DZ_LO  = 32'h0000_0000;
  localparam logic        DZ_FLG = 1'b1;
`else
  localparam int          DZ_LAT = 33;
  localparam logic [31:0] DZ_LO  = 32'h0000_0001;
  localparam logic        DZ_FLG = 1'b0;
`endif

  muldiv_unit #(.WIDTH(32)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Start   (Start),
    .Op      (Op),
    .A       (A),
    .B       (B),
    .Busy    (Busy),
    .Done    (Done),
    .HI      (HI),
    .LO      (LO),
    .DivZero (DivZero)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Called at #1 after a clock edge; Start is sampled on the next edge.
  task automatic applyStimulus(input string name, input logic op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] hi,
                               input logic [31:0] lo, input logic dz, input int lat);
    exp_t e;
    Start = 1'b1; Op = op; A = a; B = b;
    e.name = name; e.hi = hi; e.lo = lo; e.dz = dz; e.due = cyc + 1 + lat;
    sb.push_back(e);
    @(posedge Clock); #1;
    Start = 1'b0;
    checkOutput({name, "_busy"}, {31'd0, Busy}, 32'd1);
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 300 && sb.size() != 0; i++) begin
      @(posedge Clock); #1;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending required 0", sb.size());
      sb.delete();
    end
    @(posedge Clock); #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clock); #1;
      if (Done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got Done=1 at cycle %0d required no pending op", cyc);
        end else begin
          e = sb.pop_front();
          checkOutput({e.name, "_hi"}, HI, e.hi);
          checkOutput({e.name, "_lo"}, LO, e.lo);
          checkOutput({e.name, "_dz"}, {31'd0, DivZero}, {31'd0, e.dz});
          checkOutput({e.name, "_latency"}, 32'(cyc), 32'(e.due));
          checkOutput({e.name, "_busy_at_done"}, {31'd0, Busy}, 32'd0);
        end
      end else if (sb.size() != 0 && cyc > sb[0].due) begin
        e = sb.pop_front();
        checks++;
        errors++;
        $display("[TB] FAIL %s_timeout: got no Done by cycle %0d required Done at %0d", e.name, cyc, e.due);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got no finish by 200000ns required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int s;
    Reset = 1'b1; Start = 1'b0; Op = OP_MUL; A = '0; B = '0;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    checkOutput("rst_busy", {31'd0, Busy}, 32'd0);
    checkOutput("rst_done", {31'd0, Done}, 32'd0);
    checkOutput("rst_hi", HI, 32'd0);
    checkOutput("rst_lo", LO, 32'd0);
    checkOutput("rst_dz", {31'd0, DivZero}, 32'd0);

    applyStimulus("mul_7_m3", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33);
    waitIdle();
    applyStimulus("div_m17_5", OP_DIV, 32'hFFFF_FFEF, 32'd5, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 33);
    waitIdle();
    applyStimulus("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33);
    waitIdle();
    applyStimulus("div_100_7", OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);
    waitIdle();
    applyStimulus("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 33);
    waitIdle();
    applyStimulus("mul_m1_m1", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0, 33);
    waitIdle();
    applyStimulus("mul_shift", OP_MUL, 32'h1234_5678, 32'h10, 32'd1, 32'h2345_6780, 1'b0, 33);
    waitIdle();

    // A Start during Busy must neither restart nor queue a second op.
    applyStimulus("mul_min_min", OP_MUL, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 1'b0, 33);
    repeat (9) begin @(posedge Clock); #1; end
    Start = 1'b1; Op = OP_DIV; A = 32'd1; B = 32'd1;
    @(posedge Clock); #1;
    Start = 1'b0;
    waitIdle();

    applyStimulus("div_m9_0", OP_DIV, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, DZ_LO, DZ_FLG, DZ_LAT);
    waitIdle();
    applyStimulus("mul_after_dz", OP_MUL, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 33);
    waitIdle();

    // Abort a mul with Reset at edge 15, then restart at edge 17.
    Start = 1'b1; Op = OP_MUL; A = 32'd5; B = 32'd5;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (14) begin @(posedge Clock); #1; end
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    checkOutput("abort_busy", {31'd0, Busy}, 32'd0);
    checkOutput("abort_done", {31'd0, Done}, 32'd0);
    checkOutput("abort_hi", HI, 32'd0);
    checkOutput("abort_lo", LO, 32'd0);
    checkOutput("abort_dz", {31'd0, DivZero}, 32'd0);
    @(posedge Clock); #1;
    applyStimulus("mul_after_rst", OP_MUL, 32'd1000, 32'd1000, 32'd0, 32'h000F_4240, 1'b0, 33);
    waitIdle();

    // Start held high: accepts at s, s+34, s+68.
    s = cyc + 1;
    Start = 1'b1; Op = OP_MUL; A = 32'd12345; B = 32'hFFFF_FFFE;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e.name = $sformatf("held_%0d", k);
      e.hi = 32'hFFFF_FFFF; e.lo = 32'hFFFF_9F8E; e.dz = 1'b0; e.due = s + 33 + 34 * k;
      sb.push_back(e);
    end
    repeat (69) begin @(posedge Clock); #1; end
    Start = 1'b0;
    waitIdle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
